// File: rtl/seq_mult_unit.sv
// Shift-and-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, start/busy/done handshake.
// Optional two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN (adds signed_md port).
module seq_mult_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_md,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Most-negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag = (signed_md && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag = (signed_md && b_in[WIDTH-1]) ? -b_in : b_in;
    end
`else
    always_comb begin
        a_mag = a_in;
        b_mag = b_in;
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    prod_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = signed_md & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
`endif
                end
            end
            S_CALC: begin
                if (b_q != '0) begin
                    if (b_q[0]) begin
                        prod_d = prod_q + a_q;
                    end
                    a_d    = a_q << 1;
                    b_d    = b_q >> 1;
                    busy_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef SEQ_MULT_SIGNED_EN
                    if (neg_q) begin
                        prod_d = -prod_q;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit (WIDTH=16): directed cases plus random
// operands compared against an arithmetic product/latency model.
module tb_seq_mult_unit;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
`ifdef SEQ_MULT_SIGNED_EN
    logic           signed_md = 1'b0;
`endif
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_md (signed_md),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a,
                                                  input logic [W-1:0] b,
                                                  input bit sm);
        longint pa, pb, p;
        pa = longint'(a);
        pb = longint'(b);
        if (sm && a[W-1]) pa = pa - (longint'(1) << W);
        if (sm && b[W-1]) pb = pb - (longint'(1) << W);
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Edges from the start-sampling edge until done is visible.
    function automatic int model_lat(input logic [W-1:0] b, input bit sm);
        longint m;
        int k;
        m = longint'(b);
        if (sm && b[W-1]) m = (longint'(1) << W) - m;
        k = 0;
        while (m != 0) begin
            k++;
            m = m >> 1;
        end
        return k + 1;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sm, input bit inject, input string tag);
        logic [2*W-1:0] exp_p;
        int exp_l, edges, busy_cyc;
        bit got;
        exp_p = model_prod(a, b, sm);
        exp_l = model_lat(b, sm);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
`ifdef SEQ_MULT_SIGNED_EN
        signed_md = sm;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (inject) begin
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            start = 1'b1;
        end
        edges = 0;
        busy_cyc = 0;
        got = 0;
        while (!got && edges < W + 4) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (done) got = 1;
        end
        check({tag, "/done_seen"}, 64'(got), 64'd1);
        check({tag, "/latency"}, 64'(edges), 64'(exp_l));
        check({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(exp_l));
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "/product"}, 64'(product), 64'(exp_p));
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, 64'(done), 64'd0);
        check({tag, "/hold"}, 64'(product), 64'(exp_p));
    endtask

    initial begin
        int dcnt, guard;
        logic [W-1:0] ra, rb;
        bit rs;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd5, 16'd3, 1'b0, 1'b0, "a5_b3");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "max_max");
        run_op(16'h1234, 16'h0000, 1'b0, 1'b0, "b_zero");
        run_op(16'h0000, 16'h8001, 1'b0, 1'b0, "a_zero");
        run_op(16'h00AB, 16'h0F0F, 1'b0, 1'b1, "start_mid_calc");

        // Reset sampled on the 4th CALC edge aborts with no done pulse.
        @(negedge clk);
        a_in = 16'h1111;
        b_in = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/done", 64'(done), 64'd0);
        check("rst_mid/product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        check("rst_mid/no_activity", 64'(dcnt), 64'd0);

        // Start held high: one idle cycle after DONE, then a new accept.
        @(negedge clk);
        a_in = 16'd7;
        b_in = 16'd9;
        start = 1'b1;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!done && guard < W + 4);
        check("hold_start/first_done", 64'(done), 64'd1);
        check("hold_start/first_prod", 64'(product), 64'd63);
        @(posedge clk);
        #1;
        check("hold_start/idle_gap", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("hold_start/reaccept", 64'(busy), 64'd1);
        start = 1'b0;
        guard = 0;
        while (!done && guard < W + 4) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("hold_start/second_prod", 64'(product), 64'd63);
        @(posedge clk);
        #1;

`ifdef SEQ_MULT_SIGNED_EN
        run_op(16'hFFFD, 16'd5, 1'b1, 1'b0, "s_neg3_x5");
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, "s_min_min");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "u_8000_8000");
        run_op(16'h0007, 16'hFFFF, 1'b1, 1'b0, "s_7_neg1");
`endif

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, W - 1);
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
